// File: rtl/seq_detector.sv
// Parametrised serial sequence detector with KMP-style fallback and runtime overlap mode.
// Optional saturating match counter is built only when SEQ_DET_COUNT_EN is defined.
module seq_detector #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_en,
  input  logic                       x,
  input  logic                       overlap,
  output logic                       match,
  output logic [$clog2(N+1)-1:0]     progress,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int PW = $clog2(N+1);

  function automatic int calc_border();
    int best;
    best = 0;
    for (int b = 1; b < N; b++) begin
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < b; i++) begin
        if (PATTERN[i] != PATTERN[N-b+i]) ok = 1'b0;
      end
      if (ok) best = b;
    end
    return best;
  endfunction

  localparam int             BORDER   = calc_border();
  localparam logic [PW-1:0]  BORDER_P = PW'(BORDER);
  localparam logic [PW-1:0]  FULL_P   = PW'(N);

  logic [PW-1:0] prog_q, prog_d;
  logic [N-2:0]  hist_q, hist_d;
  logic          match_q, match_d;
  logic [PW-1:0] best;

  // window[0] is the bit being sampled now, window[N-1] the oldest remembered bit
  logic [N-1:0]  window;
  logic [N:1]    pfx_hit;

  assign window = {hist_q, x};

  // pfx_hit[j]: the newest j bits equal the first j pattern bits
  genvar gi;
  generate
    for (gi = 1; gi <= N; gi++) begin : g_pfx
      assign pfx_hit[gi] = (window[gi-1:0] == PATTERN[N-1 -: gi]);
    end
  endgenerate

  always_comb begin
    prog_d  = prog_q;
    hist_d  = hist_q;
    match_d = 1'b0;
    best    = '0;
    if (clk_en) begin
      hist_d = window[N-2:0];
      // Longest prefix ending at this bit, no longer than k+1; covers both advance and fallback
      for (int j = 1; j <= N; j++) begin
        if (pfx_hit[j] && (j <= int'(prog_q) + 1)) best = PW'(j);
      end
      if (best == FULL_P) begin
        match_d = 1'b1;
        prog_d  = overlap ? BORDER_P : '0;
      end else begin
        prog_d  = best;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_q  <= '0;
      hist_q  <= '0;
      match_q <= 1'b0;
    end else begin
      prog_q  <= prog_d;
      hist_q  <= hist_d;
      match_q <= match_d;
    end
  end

  assign match    = match_q;
  assign progress = prog_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (match_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: directed scenarios plus random stimulus
// against a suffix/prefix string model of the detector.
module tb_seq_detector;
  localparam int             N   = 4;
  localparam logic [N-1:0]   PAT = 4'b1011;
  localparam int             CW  = 2;
  localparam int             PW  = $clog2(N+1);
`ifdef SEQ_DET_COUNT_EN
  localparam int CNT_SAT = (1 << CW) - 1;
  localparam bit HAS_CNT = 1'b1;
`else
  localparam int CNT_SAT = 0;
  localparam bit HAS_CNT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, clk_en, x, overlap;
  logic          match;
  logic [PW-1:0] progress;
  logic [CW-1:0] match_cnt;

  seq_detector #(.N(N), .PATTERN(PAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .x(x), .overlap(overlap),
    .match(match), .progress(progress), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Model: bits received since the last cut point; state = longest suffix that is a pattern prefix
  bit           hist_m[$];
  int           m_prog, m_cnt, border_m;
  bit           m_match;
  logic [N-1:0] pat_v;

  function automatic bit pat_bit(input int i);
    return pat_v[N-1-i];
  endfunction

  function automatic int suffix_prefix();
    int sz;
    sz = hist_m.size();
    for (int j = (sz < N) ? sz : N; j > 0; j--) begin
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < j; i++)
        if (hist_m[sz-j+i] != pat_bit(i)) ok = 1'b0;
      if (ok) return j;
    end
    return 0;
  endfunction

  task automatic step(input bit r, input bit en, input bit xb, input bit ov, input string tag);
    int j;
    reset = r; clk_en = en; x = xb; overlap = ov;
    @(posedge clk);
    #1;
    if (r) begin
      hist_m.delete();
      m_prog = 0; m_match = 1'b0; m_cnt = 0;
    end else if (en) begin
      hist_m.push_back(xb);
      j = suffix_prefix();
      if (j == N) begin
        m_match = 1'b1;
        if (HAS_CNT && m_cnt < CNT_SAT) m_cnt++;
        if (ov) begin
          while (hist_m.size() > border_m) void'(hist_m.pop_front());
          m_prog = border_m;
        end else begin
          hist_m.delete();
          m_prog = 0;
        end
      end else begin
        m_match = 1'b0;
        m_prog  = j;
        while (hist_m.size() > N-1) void'(hist_m.pop_front());
      end
    end else begin
      m_match = 1'b0;
    end
    if (match) pulses++;
    $display("%s r=%0b en=%0b x=%0b ov=%0b -> match=%0b progress=%0d cnt=%0d",
             tag, r, en, xb, ov, match, progress, match_cnt);
    check({tag, "_match"}, int'(match), int'(m_match));
    check({tag, "_prog"},  int'(progress), m_prog);
    check({tag, "_cnt"},   int'(match_cnt), m_cnt);
  endtask

  task automatic feed(input logic [15:0] bits, input int len, input bit ov, input string tag);
    for (int i = len-1; i >= 0; i--) step(1'b0, 1'b1, bits[i], ov, tag);
  endtask

  initial begin
    pat_v = PAT;
    border_m = 0;
    for (int b = N-1; b >= 1 && border_m == 0; b--) begin
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < b; i++) if (pat_bit(i) != pat_bit(N-b+i)) ok = 1'b0;
      if (ok) border_m = b;
    end
    reset = 1'b1; clk_en = 1'b0; x = 1'b0; overlap = 1'b0; pulses = 0;

    // Reset state
    step(1'b1, 1'b1, 1'b1, 1'b1, "rst");
    check("rst_prog", int'(progress), 0);
    check("rst_match", int'(match), 0);

    // Overlapping stream 1011011
    pulses = 0;
    feed(16'b1011, 4, 1'b1, "ov");
    check("ov_prog4", int'(progress), 1);
    feed(16'b011, 3, 1'b1, "ov");
    check("ov_pulses", pulses, 2);

    // Non-overlapping stream 1011011
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst");
    pulses = 0;
    feed(16'b1011011, 7, 1'b0, "nov");
    check("nov_pulses", pulses, 1);
    check("nov_prog7", int'(progress), 1);

    // Fallback: 101011
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst");
    pulses = 0;
    feed(16'b1010, 4, 1'b1, "fb");
    check("fb_prog4", int'(progress), 2);
    check("fb_early", pulses, 0);
    feed(16'b11, 2, 1'b1, "fb");
    check("fb_pulses", pulses, 1);

    // Reset mid-sequence
    feed(16'b101, 3, 1'b1, "mid");
    step(1'b1, 1'b1, 1'b1, 1'b1, "mid_rst");
    pulses = 0;
    feed(16'b1, 1, 1'b1, "mid");
    check("mid_prog", int'(progress), 1);
    check("mid_cnt", int'(match_cnt), 0);
    check("mid_pulses", pulses, 0);

    // Stall of three disabled cycles before the completing bit
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst");
    feed(16'b101, 3, 1'b1, "stl");
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, "stl_hold");
      check("stl_hold_prog", int'(progress), 3);
    end
    check("stl_no_pulse", pulses, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, "stl");
    check("stl_match", int'(match), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "stl_after");
    check("stl_pulses", pulses, 1);

    // Five overlapping matches: counter saturates when built
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst");
    pulses = 0;
    feed(16'b1011, 4, 1'b1, "sat");
    for (int k = 0; k < 4; k++) feed(16'b011, 3, 1'b1, "sat");
    check("sat_pulses", pulses, 5);
    check("sat_cnt", int'(match_cnt), CNT_SAT);

    // Random traffic
    step(1'b1, 1'b0, 1'b0, 1'b0, "rst");
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
